// File: rtl/player_input_checker.sv
// player_input_checker: checks the player's arrow presses against a captured move sequence.
// Optional per-move response timeout is compiled in with CHECKER_TIMEOUT_EN.
module player_input_checker #(
    parameter int NUM_MOVES      = 4,
    parameter int TIMEOUT_CYCLES = 150000000,
    localparam int IW            = $clog2(NUM_MOVES + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2*NUM_MOVES-1:0] move_seq,
    input  logic [3:0]             key,
    output logic                   busy,
    output logic                   pass,
    output logic                   fail,
    output logic [1:0]             fail_code,
    output logic                   done,
    output logic [IW-1:0]          move_idx
);
    typedef enum logic [2:0] {IDLE, RELEASE, PRESS, PASS, FAIL} state_t;
    state_t state, state_next;
    logic [3:0] k1, ksync;
    logic [2*NUM_MOVES-1:0] seq_q, seq_sh;
    logic [IW-1:0] idx_next;
    logic [1:0] code_next, dir, cur;
    logic multi, expired, done_next;
    assign busy = state == RELEASE || state == PRESS;
    assign pass = state == PASS;
    assign fail = state == FAIL;
    assign multi = (ksync & (ksync - 4'd1)) != 4'd0;
    assign dir = {ksync[3] | ksync[2], ksync[3] | ksync[1]};
    assign seq_sh = seq_q >> {move_idx, 1'b0};
    assign cur = seq_sh[1:0];
`ifdef CHECKER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmr;
    assign expired = tmr == TW'(TIMEOUT_CYCLES - 1);
    // response timer: cleared on entry to PRESS, counts idle PRESS cycles
    always_ff @(posedge clock)
        tmr <= !reset_n ? '0 :
               (state_next == PRESS && state != PRESS) ? '0 :
               (state == PRESS && ksync == 4'd0) ? tmr + 1'b1 : tmr;
`else
    assign expired = 1'b0;
`endif
    // two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clock) begin
        k1    <= reset_n ? key : 4'd0;
        ksync <= reset_n ? k1 : 4'd0;
    end
    // state register
    always_ff @(posedge clock)
        state <= reset_n ? state_next : IDLE;
    // next-state, progress and verdict; start overrides everything
    always_comb begin
        state_next = state;
        idx_next   = move_idx;
        code_next  = fail_code;
        if (start) begin
            state_next = RELEASE;
            idx_next   = '0;
            code_next  = 2'b00;
        end else if (state == RELEASE) begin
            state_next = ksync == 4'd0 ? PRESS : RELEASE;
        end else if (state == PRESS && ksync != 4'd0) begin
            if (multi) begin
                state_next = FAIL;
                code_next  = 2'b10;
            end else if (dir != cur) begin
                state_next = FAIL;
                code_next  = 2'b01;
            end else begin
                idx_next   = move_idx + 1'b1;
                state_next = move_idx == IW'(NUM_MOVES - 1) ? PASS : RELEASE;
            end
        end else if (state == PRESS && expired) begin
            state_next = FAIL;
            code_next  = 2'b11;
        end
        done_next = (state_next == PASS || state_next == FAIL) && !(state == PASS || state == FAIL);
    end
    // datapath registers: captured sequence, progress, verdict code, done pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seq_q     <= '0;
            move_idx  <= '0;
            fail_code <= 2'b00;
            done      <= 1'b0;
        end else begin
            seq_q     <= start ? move_seq : seq_q;
            move_idx  <= idx_next;
            fail_code <= code_next;
            done      <= done_next;
        end
    end
endmodule

// File: tb/tb_player_input_checker.sv
// tb_player_input_checker: directed self-checking bench for player_input_checker.
module tb_player_input_checker;
    logic clock = 0, reset_n = 0, start = 0;
    logic [7:0] move_seq = '0;
    logic [3:0] key = '0;
    logic busy, pass, fail, done;
    logic [1:0] fail_code;
    logic [2:0] move_idx;
    int checks = 0, failures = 0, done_total = 0, base = 0;

    player_input_checker #(.NUM_MOVES(4), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .move_seq(move_seq), .key(key),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .done(done), .move_idx(move_idx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done) done_total <= done_total + 1;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] s);
        move_seq = s;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic press(input logic [3:0] k);
        key = k;
        tick(3);
        key = 0;
        tick(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_code", fail_code, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", move_idx, 0);
        reset_n = 1;
        tick(2);

        base = done_total;
        do_start(8'b11_10_01_00);
        chk("start_busy", busy, 1);
        move_seq = 8'h00;
        press(4'b0001);
        chk("seq_idx1", move_idx, 1);
        press(4'b0010);
        press(4'b0100);
        key = 4'b1000;
        tick(3);
        chk("seq_pass", pass, 1);
        chk("seq_done", done, 1);
        chk("seq_idx4", move_idx, 4);
        key = 0;
        tick(3);
        chk("seq_pass_hold", pass, 1);
        chk("seq_fail", fail, 0);
        chk("seq_code", fail_code, 0);
        chk("seq_busy", busy, 0);
        chk("seq_done_cnt", done_total - base, 1);

        do_start(8'b11_10_01_00);
        chk("restart_pass_clr", pass, 0);
        press(4'b0001);
        key = 4'b0100;
        tick(2);
        chk("wrong_early_fail", fail, 0);
        chk("wrong_early_done", done, 0);
        tick();
        chk("wrong_fail", fail, 1);
        chk("wrong_done", done, 1);
        chk("wrong_code", fail_code, 2'b01);
        chk("wrong_idx", move_idx, 1);
        tick();
        chk("wrong_done_end", done, 0);
        key = 0;
        tick(3);

        do_start(8'b11_10_01_00);
        chk("start_clr_fail", fail, 0);
        chk("start_clr_code", fail_code, 0);
        key = 4'b0011;
        tick(3);
        chk("multi_fail", fail, 1);
        chk("multi_code", fail_code, 2'b10);
        chk("multi_idx", move_idx, 0);
        key = 0;
        tick(3);

        do_start(8'b11_10_01_00);
`ifdef CHECKER_TIMEOUT_EN
        tick(16);
        chk("to_early_fail", fail, 0);
        chk("to_early_busy", busy, 1);
        tick();
        chk("to_fail", fail, 1);
        chk("to_code", fail_code, 2'b11);
        chk("to_done", done, 1);
`else
        tick(1000);
        chk("noto_busy", busy, 1);
        chk("noto_fail", fail, 0);
        chk("noto_code", fail_code, 0);
`endif

        do_start(8'b11_10_01_00);
        key = 4'b0001;
        tick(20);
        chk("hold_idx", move_idx, 1);
        chk("hold_fail", fail, 0);
        chk("hold_busy", busy, 1);
        reset_n = 0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_idx", move_idx, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_fail", fail, 0);
        chk("midrst_code", fail_code, 0);
        chk("midrst_done", done, 0);
        reset_n = 1;
        key = 0;
        tick(3);

        key = 4'b0001;
        tick(3);
        do_start(8'b11_10_01_00);
        tick(5);
        chk("held_idx", move_idx, 0);
        chk("held_busy", busy, 1);
        key = 0;
        tick(3);
        key = 4'b0001;
        tick(3);
        chk("held_then_idx", move_idx, 1);
        key = 0;
        tick(4);
        key = 4'b0010;
        tick(2);
        do_start(8'b11_10_01_00);
        chk("sp_idx", move_idx, 0);
        chk("sp_busy", busy, 1);
        tick(4);
        chk("sp_release_fail", fail, 0);
        chk("sp_release_idx", move_idx, 0);
        key = 0;
        tick(4);
        key = 4'b0001;
        tick(3);
        chk("sp_after_idx", move_idx, 1);
        key = 0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
